// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-flow controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Eight states, dense 3-bit encoding: every code is a named state.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Pick the per-port flag addressed by a; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] v,
                                      input logic [ADDR_W-1:0]    a);
        logic r;
        r = 1'b0;
        case (a)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM and its register block / synchronizer.
// Latency: n/a (wires only).
// Backpressure: busy tells the source to hold data; fifo_full stalls the FSM.
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_pkt;

    // FSM side
    modport master (
        input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

    // Register block / synchronizer / source side
    modport slave (
        output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

endinterface

// File: rtl/router_fsm_wait_timer.sv
// Counts cycles spent in WAIT_TILL_EMPTY and flags the last allowed cycle.
// Latency: expired is combinational from the count register (asserted in cycle TIMEOUT_CYCLES).
// Backpressure: none; counter clears whenever run drops.
module router_fsm_wait_timer #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int CNT_W          = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while waiting, restart from zero on any other state.
    always_ff @(posedge clock) begin
        if (!resetn)
            cnt_q <= '0;
        else if (run)
            cnt_q <= cnt_q + 1'b1;
        else
            cnt_q <= '0;
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/router_fsm.sv
// Router packet-flow FSM: header decode, payload load, full stall, parity check (opt. ROUTER_FSM_TIMEOUT_EN).
// Latency: Moore outputs straight from the state register; one edge per transition.
// Backpressure: busy asks the source to hold; fifo_full parks the FSM in FIFO_FULL_STATE.
module router_fsm
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int CNT_W          = 5
) (
    input  logic          clock,
    input  logic          resetn,
    router_fsm_if.master  bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
        $error("router_fsm: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [NUM_PORTS-1:0] empties, softs;
    logic              empty_new, empty_cur, soft_cur;

    assign empties   = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign softs     = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign empty_new = port_sel(empties, bus.data_in);
    assign empty_cur = port_sel(empties, addr_q);
    assign soft_cur  = port_sel(softs, addr_q);

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic wait_expired, drop_d, drop_q;

    router_fsm_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .run     (state_q == WAIT_TILL_EMPTY),
        .expired (wait_expired)
    );

    // Drop only when the timeout is what actually ends the wait.
    assign drop_d = (state_q == WAIT_TILL_EMPTY) && wait_expired && !empty_cur && !soft_cur;

    // Register the drop so it shows as a single pulse alongside DECODE_ADDRESS.
    always_ff @(posedge clock) begin
        if (!resetn)
            drop_q <= 1'b0;
        else
            drop_q <= drop_d;
    end

    assign bus.drop_pkt = drop_q;
`else
    assign bus.drop_pkt = 1'b0;
`endif

    // State register and destination-port latch.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && bus.pkt_valid && bus.data_in != ADDR_INVALID)
                addr_q <= bus.data_in;
        end
    end

    // Next-state logic; soft reset of the selected port overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
                    state_d = empty_new ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_cur)
                    state_d = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_TIMEOUT_EN
                else if (wait_expired)
                    state_d = DECODE_ADDRESS;
`endif
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        if (state_q != DECODE_ADDRESS && soft_cur)
            state_d = DECODE_ADDRESS;
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                               (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: driver queues expected output vectors, monitor compares.
// Latency: each expectation is the output set visible just after the next rising edge.
// Backpressure: n/a (directed stimulus).
module tb_router_fsm;

    // Output vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy, drop}
    localparam logic [8:0] E_DA    = 9'b1_0000_0000;
    localparam logic [8:0] E_DROP  = 9'b1_0000_0001;
    localparam logic [8:0] E_LFD   = 9'b0_1000_0010;
    localparam logic [8:0] E_LD    = 9'b0_0100_1000;
    localparam logic [8:0] E_LAF   = 9'b0_0010_1010;
    localparam logic [8:0] E_FULL  = 9'b0_0001_0010;
    localparam logic [8:0] E_LP    = 9'b0_0000_1010;
    localparam logic [8:0] E_CPE   = 9'b0_0000_0110;
    localparam logic [8:0] E_WTE   = 9'b0_0000_0010;

    logic clock;
    logic resetn;
    router_fsm_if bus ();

    router_fsm #(.TIMEOUT_CYCLES(30), .CNT_W(5)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [8:0] obs;
    assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                  bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_pkt};

    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Queue the expectation for the coming edge, then move to the next falling edge.
    task automatic tick(input logic [8:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clock);
    endtask

    // Monitor: compare after every rising edge that has a pending expectation.
    initial begin
        logic [8:0] e;
        string      n;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                n_checks++;
                if (obs === e)
                    n_pass++;
                else
                    $display("FAIL %s: got %b expected %b", n, obs, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn            = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        @(negedge clock);
        tick(E_DA, "reset");
        tick(E_DA, "reset_hold");
        resetn = 1'b1;

        // Plain packet to port 1
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        tick(E_LFD, "p1_lfd");
        tick(E_LD,  "p1_ld");
        tick(E_LD,  "p1_ld_hold");
        bus.pkt_valid = 1'b0;
        tick(E_LP,  "p1_lp");
        tick(E_CPE, "p1_cpe");
        tick(E_DA,  "p1_da");

        // Port 0 busy: wait until empty
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b0;
        tick(E_WTE, "p2_wait");
        repeat (4) tick(E_WTE, "p2_wait_hold");
        bus.fifo_empty_0 = 1'b1;
        tick(E_LFD, "p2_lfd");
        tick(E_LD,  "p2_ld");
        bus.pkt_valid = 1'b0;
        tick(E_LP,  "p2_lp");
        tick(E_CPE, "p2_cpe");
        tick(E_DA,  "p2_da");

        // FIFO full stall and the three exits of LOAD_AFTER_FULL
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        tick(E_LFD, "p3_lfd");
        tick(E_LD,  "p3_ld");
        bus.fifo_full = 1'b1;
        repeat (4) tick(E_FULL, "p3_full");
        bus.fifo_full = 1'b0;
        tick(E_LAF, "p3_laf");
        tick(E_LD,  "p3_laf_to_ld");
        bus.fifo_full = 1'b1;
        tick(E_FULL, "p3_full2");
        bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
        tick(E_LAF, "p3_laf2");
        tick(E_LP,  "p3_laf_to_lp");
        bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
        tick(E_CPE, "p3_cpe");
        tick(E_FULL, "p3_cpe_to_full");
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        tick(E_LAF, "p3_laf3");
        tick(E_DA,  "p3_laf_to_da");
        bus.parity_done = 1'b0;

        // fifo_full and pkt_valid fall together: stall wins
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        tick(E_LFD, "p4_lfd");
        tick(E_LD,  "p4_ld");
        bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
        tick(E_FULL, "p4_full_wins");
        bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
        tick(E_LAF, "p4_laf");
        tick(E_LP,  "p4_lp");
        bus.low_pkt_valid = 1'b0;
        tick(E_CPE, "p4_cpe");
        tick(E_DA,  "p4_da");

        // Soft reset: only the selected port counts, and it beats normal transitions
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        tick(E_LFD, "p5_lfd");
        tick(E_LD,  "p5_ld");
        bus.soft_reset_0 = 1'b1;
        tick(E_LD,  "p5_sr0_ignored");
        bus.soft_reset_0 = 1'b0; bus.soft_reset_2 = 1'b1; bus.pkt_valid = 1'b0;
        tick(E_DA,  "p5_sr2_da");
        bus.soft_reset_2 = 1'b0;
        tick(E_DA,  "p5_idle");
        bus.pkt_valid = 1'b1; bus.fifo_empty_2 = 1'b0;
        tick(E_WTE, "p5_wait");
        bus.soft_reset_2 = 1'b1; bus.pkt_valid = 1'b0;
        tick(E_DA,  "p5_sr2_wait_da");
        bus.soft_reset_2 = 1'b0; bus.fifo_empty_2 = 1'b1;

        // Invalid address stays in decode
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        tick(E_DA,  "p6_invalid");
        tick(E_DA,  "p6_invalid_hold");

        // Reset in the middle of a packet
        bus.data_in = 2'd1;
        tick(E_LFD, "p7_lfd");
        tick(E_LD,  "p7_ld");
        resetn = 1'b0;
        tick(E_DA,  "p7_reset");
        resetn = 1'b1; bus.pkt_valid = 1'b0;
        tick(E_DA,  "p7_after_reset");

        // Long wait on port 1
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b0;
        tick(E_WTE, "p8_wait");
        bus.pkt_valid = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
        repeat (29) tick(E_WTE, "p8_wait_hold");
        tick(E_DROP, "p8_drop");
        tick(E_DA,   "p8_drop_clear");
        bus.pkt_valid = 1'b1;
        tick(E_WTE, "p8_wait2");
        bus.pkt_valid = 1'b0;
        repeat (29) tick(E_WTE, "p8_wait2_hold");
        bus.fifo_empty_1 = 1'b1;
        tick(E_LFD, "p8_empty_wins");
`else
        repeat (39) tick(E_WTE, "p8_wait_hold");
        bus.fifo_empty_1 = 1'b1;
        tick(E_LFD, "p8_lfd");
`endif
        tick(E_LD,  "p8_ld");
        tick(E_LP,  "p8_lp");
        tick(E_CPE, "p8_cpe");
        tick(E_DA,  "p8_da");

        @(negedge clock);
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-flow controller for the 1x3 router.
- Sequences header decode, payload load, FIFO-full stall and parity check for one incoming packet at a time.
- Drives the register block (lfd/ld/laf/full/rst_int_reg) and the synchronizer's write_enb_reg/detect_add.
- Consumes the synchronizer's fifo_full and soft_reset_x, plus FIFO empty flags.

Parameters:
TIMEOUT_CYCLES, 30, WAIT_TILL_EMPTY cycles before the packet is dropped (used only with the optional feature).
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  source packet valid
data_in  input  2  header address bits [1:0]; 3 is invalid
parity_done  input  1  register block: parity byte captured
low_pkt_valid  input  1  register block: pkt_valid fell during a full stall
fifo_full  input  1  selected FIFO full (from synchronizer)
fifo_empty_0/1/2  input  1 each  output FIFO empty flags
soft_reset_0/1/2  input  1 each  per-port soft reset (from synchronizer)
detect_add  output  1  high in DECODE_ADDRESS
lfd_state  output  1  high in LOAD_FIRST_DATA
ld_state  output  1  high in LOAD_DATA
laf_state  output  1  high in LOAD_AFTER_FULL
full_state  output  1  high in FIFO_FULL_STATE
write_enb_reg  output  1  FIFO write enable to synchronizer
rst_int_reg  output  1  high in CHECK_PARITY_ERROR
busy  output  1  source must hold data
drop_pkt  output  1  one-cycle pulse on wait timeout (0 if feature absent)

Behaviour:
- Clocking and reset: one clock domain. resetn=0 at a clock edge forces DECODE_ADDRESS and clears addr_q and the counter.
- Outputs after reset: detect_add=1; all other outputs 0.
- Output decode: all outputs are Moore, decoded from the state register with zero added latency.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Address latch: addr_q <= data_in on the edge leaving DECODE_ADDRESS with pkt_valid=1 and data_in!=3.
- Transitions, evaluated in priority order:
  - DECODE_ADDRESS:
    - pkt_valid=1, data_in=n (n<3), fifo_empty_n=1 -> LOAD_FIRST_DATA.
    - pkt_valid=1, data_in=n, fifo_empty_n=0 -> WAIT_TILL_EMPTY.
    - data_in=3 or pkt_valid=0 -> stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
  - LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done=1 -> DECODE_ADDRESS.
    - else low_pkt_valid=1 -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
- Soft reset: soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next edge. It has priority over all other transitions. Soft resets of non-selected ports are ignored.
- Simultaneous fifo_full and pkt_valid fall in LOAD_DATA: full wins (stall first). low_pkt_valid later routes through to parity.
- State encoding: one-hot is permitted. Illegal states recover to DECODE_ADDRESS.

Optional Feature:
- ROUTER_FSM_TIMEOUT_EN defined:
  - Counter runs while in WAIT_TILL_EMPTY and clears on any other state.
  - When it reaches TIMEOUT_CYCLES-1 without fifo_empty[addr_q]: next state DECODE_ADDRESS, drop_pkt=1 for exactly one cycle.
  - Empty on the same cycle as expiry: the empty wins (LOAD_FIRST_DATA, no drop).
- ROUTER_FSM_TIMEOUT_EN undefined: no counter; drop_pkt tied 0; WAIT_TILL_EMPTY waits indefinitely.

Decomposition:
- Package router_pkg:
  - state enum (8 states);
  - NUM_PORTS=3;
  - ADDR_W=2;
  - ADDR_INVALID=2'b11.
- One natural sub-module, router_fsm_wait_timer: counter plus expiry compare. Instantiated only under ROUTER_FSM_TIMEOUT_EN.

Test Plan:
- Reset, then pkt_valid=1, data_in=2'b01, fifo_empty_1=1 -> LOAD_FIRST_DATA next cycle, then LOAD_DATA. Drop pkt_valid -> LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS. write_enb_reg=1 in LOAD_DATA/LOAD_PARITY; busy=0 in LOAD_DATA.
- data_in=2'b00, fifo_empty_0=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1. Raise fifo_empty_0 -> LOAD_FIRST_DATA next cycle.
- In LOAD_DATA, assert fifo_full for 4 cycles -> FIFO_FULL_STATE with full_state=1, write_enb_reg=0. Release with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL, then LOAD_PARITY.
- soft_reset_2=1 while in LOAD_DATA with addr_q=2 -> DECODE_ADDRESS next cycle. soft_reset_0 pulsed instead -> no effect.
- data_in=2'b11, pkt_valid=1 -> stays in DECODE_ADDRESS, detect_add=1. resetn=0 mid-LOAD_DATA -> DECODE_ADDRESS, all outputs at reset values.
- ROUTER_FSM_TIMEOUT_EN, TIMEOUT_CYCLES=30: fifo_empty_1 held 0 -> exactly 30 cycles in WAIT_TILL_EMPTY, then DECODE_ADDRESS with a single drop_pkt pulse.
